// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the 8N1 UART receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } rx_state_t;

  localparam int DEFAULT_CLKS_PER_BIT = 868;
  localparam int DATA_BITS            = 8;

endpackage

// File: rtl/uart_rx_if.sv
// Receiver-side bundle: serial line in, parallel byte and status out.
interface uart_rx_if;
  import uart_pkg::*;

  logic                 rx;
  logic [DATA_BITS-1:0] rx_data;
  logic                 wr_req;
  logic                 frame_err;
  logic                 busy;

  modport master (
    input  rx,
    output rx_data,
    output wr_req,
    output frame_err,
    output busy
  );

  modport slave (
    output rx,
    input  rx_data,
    input  wr_req,
    input  frame_err,
    input  busy
  );

endinterface

// File: rtl/uart_rx_bit_sync.sv
// Generic two-flop synchroniser with a configurable reset value.
module bit_sync #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // Two-stage capture of the asynchronous input.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 LSB-first UART receiver producing a stretched write request per good byte.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int WR_HOLD      = 4
) (
  input  logic      clk,
  input  logic      rst,
  uart_rx_if.master bus
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int HW = $clog2(WR_HOLD + 1);
  localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF  = CW'(CLKS_PER_BIT / 2);
  localparam logic [HW-1:0] HOLD_LOAD = HW'(WR_HOLD - 1);

  logic                 rx_s;
  rx_state_t            state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2:0]           idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic [HW-1:0]        hold_q, hold_d;
  logic                 wr_req_q, wr_req_d;
  logic                 frame_err_q, frame_err_d;
  logic                 busy_q, busy_d;

  bit_sync #(.RESET_VAL(1'b1)) u_rx_sync (
    .clk (clk),
    .rst (rst),
    .d_i (bus.rx),
    .q_o (rx_s)
  );

  // Next-state and output decode for the receive FSM and the hold counter.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + CW'(1);
    idx_d       = idx_q;
    shift_d     = shift_q;
    data_d      = data_q;
    frame_err_d = 1'b0;
    if (hold_q != {HW{1'b0}}) begin
      hold_d   = hold_q - HW'(1);
      wr_req_d = 1'b1;
    end else begin
      hold_d   = hold_q;
      wr_req_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        // The cycle that sees the low line counts as count 0 of the start bit.
        idx_d = 3'd0;
        if (!rx_s) begin
          state_d = START;
          cnt_d   = CW'(1);
        end else begin
          cnt_d = {CW{1'b0}};
        end
      end
      START: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d   = {CW{1'b0}};
          state_d = rx_s ? IDLE : DATA;
        end else begin
          state_d = START;
        end
      end
      DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d          = {CW{1'b0}};
          shift_d[idx_q] = rx_s;
          idx_d          = idx_q + 3'd1;
          state_d        = (idx_q == 3'd7) ? STOP : DATA;
        end else begin
          state_d = DATA;
        end
      end
      STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = {CW{1'b0}};
          if (rx_s) begin
            data_d   = shift_q;
            hold_d   = HOLD_LOAD;
            wr_req_d = 1'b1;
            state_d  = IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = BREAK;
          end
        end else begin
          state_d = STOP;
        end
      end
      BREAK: begin
        cnt_d   = {CW{1'b0}};
        state_d = rx_s ? IDLE : BREAK;
      end
      default: begin
        cnt_d   = {CW{1'b0}};
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= {CW{1'b0}};
      idx_q       <= 3'd0;
      shift_q     <= {DATA_BITS{1'b0}};
      data_q      <= {DATA_BITS{1'b0}};
      hold_q      <= {HW{1'b0}};
      wr_req_q    <= 1'b0;
      frame_err_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      hold_q      <= hold_d;
      wr_req_q    <= wr_req_d;
      frame_err_q <= frame_err_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.rx_data   = data_q;
  assign bus.wr_req    = wr_req_q;
  assign bus.frame_err = frame_err_q;
  assign bus.busy      = busy_q;

endmodule
